green_square_renderer: RTL and testbench
========================================

Name: green_square_renderer

Overview:
- Display-side consumer of the square-position interface: takes the square's top-left coordinate (current_x, current_y) and the OLED driver's pixel_index.
- Returns the RGB565 colour for that pixel: background black, obstacle white, square green.
- Positions are snapshotted once per frame, so the square never tears mid-frame.
- Adds a frame-counted contact flash whenever the square sits against the obstacle.

Parameters:
- WIDTH, 96, display columns
- HEIGHT, 64, display rows
- SQ_SIZE, 9, square edge in pixels; covers columns x..x+SQ_SIZE-1 and rows y..y+SQ_SIZE-1
- OBS_X0, 65, first obstacle column; the obstacle spans columns OBS_X0..WIDTH-1
- OBS_Y1, 30, obstacle spans rows 0..OBS_Y1-1
- FLASH_FRAMES, 8, frames per flash half-period

Ports:
- clock_25Mhz  input  1  system clock
- reset  input  1  synchronous, active-high reset
- switch  input  1  task enable; low = display blanked, renderer idle
- frame_begin  input  1  one-cycle pulse from the OLED driver at the start of each frame
- pixel_index  input  13  linear index of the requested pixel, 0..WIDTH*HEIGHT-1
- current_x  input  7  square left column
- current_y  input  6  square top row
- pixel_data  output  16  RGB565 colour for pixel_index, delayed 2 cycles
- flashing  output  1  high while the contact flash is active

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - pixel_data = 16'h0000
  - flashing = 0
  - shadow_x = 0, shadow_y = 54
  - frame counter = 0
  - state = IDLE
- Shadow latch:
  - On frame_begin, shadow_x/shadow_y <= current_x/current_y.
  - All geometry for the frame uses the shadows only.
- Pipeline, 2-cycle latency:
  - Stage 1 registers col = pixel_index % WIDTH and row = pixel_index / WIDTH.
  - Stage 2 registers pixel_data from the stage-1 col/row and the shadows.
  - pixel_data at cycle t+2 answers pixel_index at cycle t, with no bubbles.
- Colour priority, highest first:
  - square: colour is 16'h07E0 (green), or 16'hFFE0 (yellow) during the flash-on half
  - obstacle: 16'hFFFF
  - otherwise 16'h0000
- Range checks:
  - Use ranges widened to 8 bits so shadow_x+SQ_SIZE cannot wrap.
  - pixel_index >= WIDTH*HEIGHT gives 16'h0000.
- State machine, updated only on frame_begin:
  - IDLE:
    - pixel_data forced to 0, frame counter held at 0, flashing = 0.
    - Go to ACTIVE on the first frame_begin with switch = 1.
  - ACTIVE:
    - Normal rendering.
    - If the latched position is in contact (shadow_x+SQ_SIZE >= OBS_X0 and shadow_y <= OBS_Y1), go to FLASH and clear the frame counter.
  - FLASH:
    - flashing = 1.
    - Frame counter increments each frame_begin, mod 2*FLASH_FRAMES.
    - Flash-on half is counter < FLASH_FRAMES.
    - Return to ACTIVE on the first frame_begin where contact is false; counter clears.
- switch low:
  - Takes effect at once in any state: pixel_data = 0 from the next stage-2 update.
  - State moves to IDLE at the next clock edge, without waiting for frame_begin.
  - Shadows are still latched on frame_begin.
- frame_begin and switch falling in the same cycle: IDLE wins.
- Reset mid-frame: the pipeline is flushed to 0 and the first two outputs after reset are 0.
- Out-of-range inputs (current_x > WIDTH-SQ_SIZE) need no special handling: pixels beyond WIDTH are simply not drawn, and wrap is prevented by the 8-bit compare.

Decomposition:
- Shared package holds:
  - display constants WIDTH, HEIGHT
  - colour constants COL_BLACK, COL_WHITE, COL_GREEN, COL_YELLOW
  - obstacle bounds OBS_X0, OBS_Y1
  - the state encoding (IDLE, ACTIVE, FLASH)
- The same obstacle bounds are used by the movement logic, so both ends share one definition.
- One natural sub-module: pixel_index_to_xy, the registered index→(col,row) stage 1, reusable by other renderers.

Test Plan:
- Reset, then switch=1, frame_begin, current=(0,54):
  - index 54*96+0 = 5184 → pixel_data 16'h07E0 two cycles later.
  - index 5184+9 = 5193 → 16'h0000.
- current=(70,40), frame_begin:
  - index 0*96+80 = 80 → 16'hFFFF (obstacle).
  - index 40*96+70 = 3910 → 16'h07E0.
- Position changed mid-frame, from (10,10) to (20,10) without frame_begin:
  - index 10*96+10 = 970 still 16'h07E0.
  - After the next frame_begin, 970 → 0 and 10*96+20 = 980 → green.
- current=(56,30) (contact), frame_begin ×20:
  - flashing=1 from the first frame.
  - Square yellow for frames 0–7, green for frames 8–15, yellow for frames 16–19.
  - Move to (40,30) → flashing=0 after the next frame_begin.
- switch=0 mid-frame while in FLASH:
  - pixel_data 0 within 2 cycles; state IDLE; flashing=0.
  - switch=1 with no frame_begin → output stays 0 until the next frame_begin.
- Pipeline throughput: pixel_index sweeps 0..6143 one per cycle:
  - 6144 outputs, each matching the model with a 2-cycle offset.
  - Exactly 81 green pixels with the square at (0,54).

Source files
------------

// File: rtl/green_square_renderer_pkg.sv
`default_nettype none
//==============================================================================
// Module      : green_square_renderer_pkg
// Description : Shared display geometry, colours, obstacle bounds and renderer
//               state encoding. The obstacle bounds are also used by the
//               square movement logic so both ends agree on one definition.
// Revision    : 1.0 - initial release
//==============================================================================
package green_square_renderer_pkg;

    // Display geometry
    localparam int WIDTH  = 96;
    localparam int HEIGHT = 64;

    // RGB565 colours
    localparam logic [15:0] COL_BLACK  = 16'h0000;
    localparam logic [15:0] COL_WHITE  = 16'hFFFF;
    localparam logic [15:0] COL_GREEN  = 16'h07E0;
    localparam logic [15:0] COL_YELLOW = 16'hFFE0;

    // Obstacle occupies columns OBS_X0..WIDTH-1 and rows 0..OBS_Y1-1
    localparam int OBS_X0 = 65;
    localparam int OBS_Y1 = 30;

    // Renderer state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLASH  = 2'd2;

    // Decoded pixel coordinate; valid is low for indices beyond the panel
    typedef struct packed {
        logic [6:0] col;
        logic [5:0] row;
        logic       valid;
    } pixel_xy_t;

    // Square touches the obstacle: right edge reaches the obstacle's first
    // column while the top row is at or above the obstacle's bottom edge.
    // Done in 8 bits so x + size can never wrap.
    function automatic logic in_contact(
        input logic [6:0] x,
        input logic [5:0] y,
        input int         sq_size,
        input int         obs_x0,
        input int         obs_y1
    );
        logic [7:0] right_edge;
        right_edge = {1'b0, x} + 8'(sq_size);
        return (right_edge >= 8'(obs_x0)) && ({2'b00, y} <= 8'(obs_y1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/green_square_renderer_pixel_index_to_xy.sv
`default_nettype none
//==============================================================================
// Module      : pixel_index_to_xy
// Description : Registered conversion of a linear OLED pixel index into
//               (column, row), with a valid flag for out-of-panel indices.
// Revision    : 1.0 - initial release
//==============================================================================
module pixel_index_to_xy
    import green_square_renderer_pkg::*;
#(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 64
) (
    input  logic        clock_25Mhz,
    input  logic        reset,
    input  logic [12:0] pixel_index,
    output pixel_xy_t   xy
);

    // Divide by the constant panel width; index beyond the panel is flagged
    always_ff @(posedge clock_25Mhz) begin
        if (reset) begin
            xy <= '0;
        end else begin
            xy.col   <= 7'(pixel_index % 13'(WIDTH));
            xy.row   <= 6'(pixel_index / 13'(WIDTH));
            xy.valid <= (pixel_index < 13'(WIDTH * HEIGHT));
        end
    end

endmodule
`default_nettype wire

// File: rtl/green_square_renderer.sv
`default_nettype none
//==============================================================================
// Module      : green_square_renderer
// Description : Renders a green square over a white obstacle on a black
//               background in RGB565. Square position is snapshotted on
//               frame_begin so a frame never tears; a frame-counted yellow
//               flash runs while the square touches the obstacle.
//               Output latency is two cycles with no bubbles.
// Revision    : 1.0 - initial release
//==============================================================================
module green_square_renderer
    import green_square_renderer_pkg::*;
#(
    parameter int WIDTH        = green_square_renderer_pkg::WIDTH,
    parameter int HEIGHT       = green_square_renderer_pkg::HEIGHT,
    parameter int SQ_SIZE      = 9,
    parameter int OBS_X0       = green_square_renderer_pkg::OBS_X0,
    parameter int OBS_Y1       = green_square_renderer_pkg::OBS_Y1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic        clock_25Mhz,
    input  logic        reset,
    input  logic        switch,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic [6:0]  current_x,
    input  logic [5:0]  current_y,
    output logic [15:0] pixel_data,
    output logic        flashing
);

    localparam int               c_CNT_W       = $clog2(2 * FLASH_FRAMES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(2 * FLASH_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [5:0]       c_SHADOW_Y_RST = 6'd54;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_frame_cnt;
    logic [6:0]         r_shadow_x;
    logic [5:0]         r_shadow_y;
    pixel_xy_t          w_xy;

    logic       w_contact;
    logic       w_flash_on;
    logic       w_in_square;
    logic       w_in_obstacle;
    logic [7:0] w_col8;
    logic [7:0] w_row8;
    logic [7:0] w_sx8;
    logic [7:0] w_sy8;
    logic [15:0] w_colour;

    // Stage 1: index -> (col, row)
    pixel_index_to_xy #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_index_to_xy (
        .clock_25Mhz (clock_25Mhz),
        .reset       (reset),
        .pixel_index (pixel_index),
        .xy          (w_xy)
    );

    // Contact is judged on the position being latched at this frame start
    assign w_contact = in_contact(current_x, current_y, SQ_SIZE, OBS_X0, OBS_Y1);

    // Snapshot the square position once per frame
    always_ff @(posedge clock_25Mhz) begin
        if (reset) begin
            r_shadow_x <= 7'd0;
            r_shadow_y <= c_SHADOW_Y_RST;
        end else if (frame_begin) begin
            r_shadow_x <= current_x;
            r_shadow_y <= current_y;
        end
    end

    // Frame-paced state machine; a low switch forces IDLE immediately
    always_ff @(posedge clock_25Mhz) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
        end else if (!switch) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
        end else if (frame_begin) begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_ACTIVE;
                    r_frame_cnt <= '0;
                end
                ST_ACTIVE: begin
                    if (w_contact) begin
                        r_state     <= ST_FLASH;
                        r_frame_cnt <= '0;
                    end
                end
                ST_FLASH: begin
                    if (!w_contact) begin
                        r_state     <= ST_ACTIVE;
                        r_frame_cnt <= '0;
                    end else if (r_frame_cnt == c_CNT_LAST) begin
                        r_frame_cnt <= '0;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_frame_cnt <= '0;
                end
            endcase
        end
    end

    // Stage-2 geometry in 8 bits so shadow + size cannot wrap
    always_comb begin
        w_col8        = {1'b0, w_xy.col};
        w_row8        = {2'b00, w_xy.row};
        w_sx8         = {1'b0, r_shadow_x};
        w_sy8         = {2'b00, r_shadow_y};
        w_in_square   = (w_col8 >= w_sx8) && (w_col8 < w_sx8 + 8'(SQ_SIZE)) &&
                        (w_row8 >= w_sy8) && (w_row8 < w_sy8 + 8'(SQ_SIZE));
        w_in_obstacle = (w_col8 >= 8'(OBS_X0)) && (w_row8 < 8'(OBS_Y1));
        w_flash_on    = (r_state == ST_FLASH) && (int'(r_frame_cnt) < FLASH_FRAMES);
        w_colour      = COL_BLACK;
        if (w_in_square) begin
            w_colour = w_flash_on ? COL_YELLOW : COL_GREEN;
        end else if (w_in_obstacle) begin
            w_colour = COL_WHITE;
        end
    end

    // Stage 2: register the colour, blanked when idle, disabled or off-panel
    always_ff @(posedge clock_25Mhz) begin
        if (reset) begin
            pixel_data <= COL_BLACK;
        end else if (!switch || (r_state == ST_IDLE) || !w_xy.valid) begin
            pixel_data <= COL_BLACK;
        end else begin
            pixel_data <= w_colour;
        end
    end

    assign flashing = (r_state == ST_FLASH);

endmodule
`default_nettype wire

// File: tb/tb_green_square_renderer.sv
`default_nettype none
//==============================================================================
// Module      : tb_green_square_renderer
// Description : Directed self-checking bench for green_square_renderer.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_green_square_renderer;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] YELLOW = 16'hFFE0;

    logic        clock_25Mhz = 1'b0;
    logic        reset;
    logic        switch;
    logic        frame_begin;
    logic [12:0] pixel_index;
    logic [6:0]  current_x;
    logic [5:0]  current_y;
    logic [15:0] pixel_data;
    logic        flashing;

    int n_assert = 0;
    int n_fail   = 0;
    int greens   = 0;

    green_square_renderer dut (
        .clock_25Mhz (clock_25Mhz),
        .reset       (reset),
        .switch      (switch),
        .frame_begin (frame_begin),
        .pixel_index (pixel_index),
        .current_x   (current_x),
        .current_y   (current_y),
        .pixel_data  (pixel_data),
        .flashing    (flashing)
    );

    always #20 clock_25Mhz = ~clock_25Mhz;

    // Reference colour for one pixel given the frame's square position
    function automatic logic [15:0] model(input int idx, input int sx, input int sy, input bit yel);
        int col;
        int row;
        col = idx % 96;
        row = idx / 96;
        if (idx >= 6144) return BLACK;
        if (col >= sx && col < sx + 9 && row >= sy && row < sy + 9) return yel ? YELLOW : GREEN;
        if (col >= 65 && row < 30) return WHITE;
        return BLACK;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after a negedge; one-cycle frame_begin pulse
    task automatic frame(input int x, input int y);
        current_x   = 7'(x);
        current_y   = 6'(y);
        frame_begin = 1'b1;
        @(negedge clock_25Mhz);
        frame_begin = 1'b0;
    endtask

    // Called right after a negedge; result observed two cycles later
    task automatic check_pix(input string tag, input int idx, input logic [15:0] exp);
        pixel_index = 13'(idx);
        @(negedge clock_25Mhz);
        @(negedge clock_25Mhz);
        chk(tag, pixel_data, exp);
    endtask

    initial begin
        reset       = 1'b1;
        switch      = 1'b0;
        frame_begin = 1'b0;
        pixel_index = '0;
        current_x   = '0;
        current_y   = '0;
        repeat (3) @(negedge clock_25Mhz);
        chk("reset_pixel", pixel_data, BLACK);
        chk("reset_flash", {15'd0, flashing}, 16'd0);
        reset = 1'b0;

        // Enabled but no frame yet: still idle, shadow square must stay blank
        switch = 1'b1;
        check_pix("idle_blank", 5184, BLACK);

        // Square at (0,54)
        frame(0, 54);
        check_pix("sq_topleft",  5184, GREEN);
        check_pix("sq_topright", 5192, GREEN);
        check_pix("sq_right_out", 5193, BLACK);
        check_pix("sq_bottom",   5960, GREEN);
        check_pix("sq_below",    6048, BLACK);
        check_pix("obs_80",      80,   WHITE);
        check_pix("idx_6144",    6144, BLACK);
        check_pix("idx_8191",    8191, BLACK);

        // Full sweep, one index per cycle
        for (int k = 0; k < 6146; k++) begin
            if (k < 6144) pixel_index = 13'(k);
            if (k >= 2) begin
                chk("sweep", pixel_data, model(k - 2, 0, 54, 1'b0));
                if (pixel_data === GREEN) greens++;
            end
            @(negedge clock_25Mhz);
        end
        chk("green_count", 16'(greens), 16'd81);

        // Square at (70,40) with obstacle bounds
        frame(70, 40);
        check_pix("obs_pix",      80,   WHITE);
        check_pix("sq_70_40",     3910, GREEN);
        check_pix("obs_lastrow",  2849, WHITE);
        check_pix("obs_belowrow", 2945, BLACK);
        check_pix("obs_leftcol",  2848, BLACK);

        // Mid-frame position change is not visible until frame_begin
        frame(10, 10);
        check_pix("pos_10_10", 970, GREEN);
        current_x = 7'd20;
        check_pix("no_tear", 970, GREEN);
        frame(20, 10);
        check_pix("old_gone", 970, BLACK);
        check_pix("new_pos",  980, GREEN);

        // Contact flash over 20 frames
        for (int f = 0; f < 20; f++) begin
            frame(56, 30);
            chk("flash_flag", {15'd0, flashing}, 16'd1);
            check_pix("flash_col", 2936, ((f % 16) < 8) ? YELLOW : GREEN);
        end
        frame(40, 30);
        chk("flash_off", {15'd0, flashing}, 16'd0);
        check_pix("after_flash_old", 2936, BLACK);
        check_pix("after_flash_new", 2920, GREEN);

        // Switch low while flashing
        frame(56, 30);
        chk("flash_again", {15'd0, flashing}, 16'd1);
        pixel_index = 13'd2936;
        switch      = 1'b0;
        @(negedge clock_25Mhz);
        chk("sw_off_flag", {15'd0, flashing}, 16'd0);
        chk("sw_off_pix1", pixel_data, BLACK);
        @(negedge clock_25Mhz);
        chk("sw_off_pix2", pixel_data, BLACK);
        switch = 1'b1;
        check_pix("sw_on_idle", 2936, BLACK);
        frame(56, 30);
        chk("resume_flag", {15'd0, flashing}, 16'd0);
        check_pix("resume_pix", 2936, GREEN);
        frame(56, 30);
        chk("reflash_flag", {15'd0, flashing}, 16'd1);
        check_pix("reflash_pix", 2936, YELLOW);

        // Reset mid-frame flushes the pipeline
        pixel_index = 13'd2936;
        reset       = 1'b1;
        @(negedge clock_25Mhz);
        reset = 1'b0;
        chk("rst_mid_pix0", pixel_data, BLACK);
        @(negedge clock_25Mhz);
        chk("rst_mid_pix1", pixel_data, BLACK);
        @(negedge clock_25Mhz);
        chk("rst_mid_pix2", pixel_data, BLACK);
        chk("rst_mid_flag", {15'd0, flashing}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
